// File: rtl/valu_seq.sv
// Vector ALU issue sequencer: walks vl elements in VECTOR_LANES-word groups,
// reading the VRF, driving the valu lanes and writing results back with byte enables.
module valu_seq #(
    parameter int VECTOR_LANES  = 8,
    parameter int MICROOP_WIDTH = 5,
    parameter int VL_W          = 9,
    parameter int GRP_W         = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         instr_valid_i,
    output logic                         instr_ready_o,
    input  logic [MICROOP_WIDTH-1:0]     instr_microop_i,
    input  logic [1:0]                   instr_vsew_i,
    input  logic [VL_W-1:0]              instr_vl_i,
    input  logic [4:0]                   instr_vs1_i,
    input  logic [4:0]                   instr_vs2_i,
    input  logic [4:0]                   instr_vd_i,
    input  logic                         instr_use_scalar_i,
    input  logic [31:0]                  instr_scalar_i,
    input  logic [31:0]                  instr_imm_i,
    output logic                         vrf_rd_en_o,
    output logic [4:0]                   vrf_rd_addr_a_o,
    output logic [4:0]                   vrf_rd_addr_b_o,
    output logic [GRP_W-1:0]             vrf_rd_grp_o,
    input  logic [VECTOR_LANES*32-1:0]   vrf_rd_data_a_i,
    input  logic [VECTOR_LANES*32-1:0]   vrf_rd_data_b_i,
    output logic [VECTOR_LANES-1:0]      lane_valid_o,
    output logic [VECTOR_LANES*32-1:0]   lane_data_a_o,
    output logic [VECTOR_LANES*32-1:0]   lane_data_b_o,
    output logic [31:0]                  lane_imm_o,
    output logic [MICROOP_WIDTH-1:0]     lane_microop_o,
    output logic [1:0]                   lane_vsew_o,
    input  logic [VECTOR_LANES*32-1:0]   lane_result_i,
    output logic                         vrf_wr_en_o,
    output logic [4:0]                   vrf_wr_addr_o,
    output logic [GRP_W-1:0]             vrf_wr_grp_o,
    output logic [VECTOR_LANES*32-1:0]   vrf_wr_data_o,
    output logic [VECTOR_LANES*4-1:0]    vrf_wr_be_o,
    input  logic                         vrf_wr_ready_i,
    output logic                         scalar_wr_en_o,
    output logic [31:0]                  scalar_wr_data_o,
    output logic                         done_o
);
    localparam int DW = VECTOR_LANES * 32;
    localparam int NB = VECTOR_LANES * 4;
    localparam int IW = VL_W + 7;
    localparam logic [MICROOP_WIDTH-1:0] OP_VMV_X_S = MICROOP_WIDTH'(5'b01011);
    localparam logic [MICROOP_WIDTH-1:0] OP_VMV_V_X = MICROOP_WIDTH'(5'b11001);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_EX, S_WB, S_DONE} state_t;

    state_t                   r_state;
    logic [MICROOP_WIDTH-1:0] r_microop;
    logic [1:0]               r_vsew;
    logic [VL_W-1:0]          r_vl;
    logic [4:0]               r_vs1, r_vs2, r_vd;
    logic                     r_use_scalar;
    logic [31:0]              r_scalar, r_imm;
    logic [VL_W-1:0]          r_grp;
    logic                     r_ready, r_rd_en, r_wr_en, r_scalar_wr_en, r_done;
    logic [DW-1:0]            r_wr_data;
    logic [NB-1:0]            r_wr_be;

    logic [1:0]               w_sh;
    logic                     w_is_vmvxs, w_in_ex, w_last;
    logic [IW-1:0]            w_grp_byte;
    logic [NB-1:0]            w_be;
    logic [VECTOR_LANES-1:0]  w_lane_valid;
    logic [31:0]              w_rep;

    function automatic logic [1:0] sew_shift(input logic [1:0] vsew);
        return (vsew == 2'b00) ? 2'd0 : (vsew == 2'b01) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [31:0] rep_scalar(input logic [31:0] s, input logic [1:0] sh);
        case (sh)
            2'd0:    return {4{s[7:0]}};
            2'd1:    return {2{s[15:0]}};
            default: return s;
        endcase
    endfunction

    assign w_sh       = sew_shift(r_vsew);
    assign w_is_vmvxs = (r_microop == OP_VMV_X_S);
    assign w_in_ex    = (r_state == S_EX);
    assign w_grp_byte = IW'(r_grp) << 5;
    assign w_rep      = rep_scalar(r_scalar, w_sh);
    // Last group once the next group's first element index reaches vl.
    assign w_last     = ((IW'(r_grp) + IW'(1)) << (3'd5 - {1'b0, w_sh})) >= IW'(r_vl);

    // Byte b of the group belongs to element (group byte offset + b) >> log2(SEWB).
    always_comb begin
        w_be         = '0;
        w_lane_valid = '0;
        for (int b = 0; b < NB; b++)
            w_be[b] = ((w_grp_byte + IW'(b)) >> w_sh) < IW'(r_vl);
        for (int l = 0; l < VECTOR_LANES; l++)
            w_lane_valid[l] = w_be[4*l];
        if (w_is_vmvxs)
            w_lane_valid = VECTOR_LANES'(1);
    end

    always_comb begin
        lane_valid_o  = w_in_ex ? w_lane_valid : '0;
        lane_data_a_o = '0;
        lane_data_b_o = '0;
        for (int l = 0; l < VECTOR_LANES; l++) begin
            if (lane_valid_o[l]) begin
                lane_data_a_o[32*l +: 32] = (r_microop == OP_VMV_V_X) ? w_rep
                                                                       : vrf_rd_data_a_i[32*l +: 32];
                lane_data_b_o[32*l +: 32] = w_is_vmvxs   ? 32'd0 :
                                            r_use_scalar ? w_rep : vrf_rd_data_b_i[32*l +: 32];
            end
        end
    end

    assign lane_imm_o       = w_in_ex ? r_imm     : '0;
    assign lane_microop_o   = w_in_ex ? r_microop : '0;
    assign lane_vsew_o      = w_in_ex ? r_vsew    : '0;
    assign instr_ready_o    = r_ready;
    assign vrf_rd_en_o      = r_rd_en;
    assign vrf_rd_addr_a_o  = r_rd_en ? r_vs2 : '0;
    assign vrf_rd_addr_b_o  = r_rd_en ? r_vs1 : '0;
    assign vrf_rd_grp_o     = r_rd_en ? r_grp[GRP_W-1:0] : '0;
    assign vrf_wr_en_o      = r_wr_en;
    assign vrf_wr_addr_o    = r_wr_en ? r_vd : '0;
    assign vrf_wr_grp_o     = r_wr_en ? r_grp[GRP_W-1:0] : '0;
    assign vrf_wr_data_o    = r_wr_en ? r_wr_data : '0;
    assign vrf_wr_be_o      = r_wr_en ? r_wr_be : '0;
    assign scalar_wr_en_o   = r_scalar_wr_en;
    assign scalar_wr_data_o = r_scalar_wr_en ? r_wr_data[31:0] : '0;
    assign done_o           = r_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_microop      <= '0;
            r_vsew         <= '0;
            r_vl           <= '0;
            r_vs1          <= '0;
            r_vs2          <= '0;
            r_vd           <= '0;
            r_use_scalar   <= 1'b0;
            r_scalar       <= '0;
            r_imm          <= '0;
            r_grp          <= '0;
            r_ready        <= 1'b1;
            r_rd_en        <= 1'b0;
            r_wr_en        <= 1'b0;
            r_scalar_wr_en <= 1'b0;
            r_done         <= 1'b0;
            r_wr_data      <= '0;
            r_wr_be        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (instr_valid_i) begin
                        r_microop    <= instr_microop_i;
                        r_vsew       <= instr_vsew_i;
                        r_vl         <= instr_vl_i;
                        r_vs1        <= instr_vs1_i;
                        r_vs2        <= instr_vs2_i;
                        r_vd         <= instr_vd_i;
                        r_use_scalar <= instr_use_scalar_i;
                        r_scalar     <= instr_scalar_i;
                        r_imm        <= instr_imm_i;
                        r_grp        <= '0;
                        r_ready      <= 1'b0;
                        // vmv.x.s reads element 0 even when vl is zero.
                        if (instr_microop_i != OP_VMV_X_S && instr_vl_i == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_RD;
                            r_rd_en <= 1'b1;
                        end
                    end
                end
                S_RD: begin
                    r_rd_en <= 1'b0;
                    r_state <= S_EX;
                end
                S_EX: begin
                    r_wr_data <= lane_result_i;
                    r_wr_be   <= w_be;
                    if (w_is_vmvxs)
                        r_scalar_wr_en <= 1'b1;
                    else
                        r_wr_en <= 1'b1;
                    r_state <= S_WB;
                end
                S_WB: begin
                    if (w_is_vmvxs) begin
                        r_scalar_wr_en <= 1'b0;
                        r_done         <= 1'b1;
                        r_state        <= S_DONE;
                    end else if (vrf_wr_ready_i) begin
                        r_wr_en <= 1'b0;
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_grp   <= r_grp + VL_W'(1);
                            r_rd_en <= 1'b1;
                            r_state <= S_RD;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_valu_seq.sv
// Self-checking bench for valu_seq: VRF and lane models around the DUT, element-level reference.
module tb_valu_seq;
    localparam int L   = 8;
    localparam int DW  = L * 32;
    localparam int NB  = L * 4;
    localparam logic [4:0] OP_VADD  = 5'b00001;
    localparam logic [4:0] OP_VMVXS = 5'b01011;
    localparam logic [4:0] OP_VMVVX = 5'b11001;
    localparam logic [4:0] OP_XOR   = 5'b00111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic instr_valid_i = 1'b0, instr_ready_o;
    logic [4:0] instr_microop_i = '0;
    logic [1:0] instr_vsew_i = '0;
    logic [8:0] instr_vl_i = '0;
    logic [4:0] instr_vs1_i = '0, instr_vs2_i = '0, instr_vd_i = '0;
    logic instr_use_scalar_i = 1'b0;
    logic [31:0] instr_scalar_i = '0, instr_imm_i = '0;
    logic vrf_rd_en_o;
    logic [4:0] vrf_rd_addr_a_o, vrf_rd_addr_b_o;
    logic [3:0] vrf_rd_grp_o;
    logic [DW-1:0] vrf_rd_data_a_i = '0, vrf_rd_data_b_i = '0;
    logic [L-1:0] lane_valid_o;
    logic [DW-1:0] lane_data_a_o, lane_data_b_o;
    logic [31:0] lane_imm_o;
    logic [4:0] lane_microop_o;
    logic [1:0] lane_vsew_o;
    logic [DW-1:0] lane_result_i;
    logic vrf_wr_en_o;
    logic [4:0] vrf_wr_addr_o;
    logic [3:0] vrf_wr_grp_o;
    logic [DW-1:0] vrf_wr_data_o;
    logic [NB-1:0] vrf_wr_be_o;
    logic vrf_wr_ready_i = 1'b1;
    logic scalar_wr_en_o;
    logic [31:0] scalar_wr_data_o;
    logic done_o;

    int checks = 0, errors = 0;
    logic [7:0] vmem [32][512];

    logic [4:0]  cur_op;
    logic [1:0]  cur_sew;
    int          cur_vl, cur_vs1, cur_vs2, cur_vd;
    logic        cur_use;
    logic [31:0] cur_sc, cur_imm;
    logic [DW-1:0] last_wr_data;
    logic [NB-1:0] last_wr_be;
    logic [L-1:0]  last_lv;
    logic [31:0]   last_scalar;
    int            last_done_cyc;

    valu_seq #(.VECTOR_LANES(L), .MICROOP_WIDTH(5), .VL_W(9), .GRP_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
        .instr_microop_i(instr_microop_i), .instr_vsew_i(instr_vsew_i), .instr_vl_i(instr_vl_i),
        .instr_vs1_i(instr_vs1_i), .instr_vs2_i(instr_vs2_i), .instr_vd_i(instr_vd_i),
        .instr_use_scalar_i(instr_use_scalar_i), .instr_scalar_i(instr_scalar_i), .instr_imm_i(instr_imm_i),
        .vrf_rd_en_o(vrf_rd_en_o), .vrf_rd_addr_a_o(vrf_rd_addr_a_o), .vrf_rd_addr_b_o(vrf_rd_addr_b_o),
        .vrf_rd_grp_o(vrf_rd_grp_o), .vrf_rd_data_a_i(vrf_rd_data_a_i), .vrf_rd_data_b_i(vrf_rd_data_b_i),
        .lane_valid_o(lane_valid_o), .lane_data_a_o(lane_data_a_o), .lane_data_b_o(lane_data_b_o),
        .lane_imm_o(lane_imm_o), .lane_microop_o(lane_microop_o), .lane_vsew_o(lane_vsew_o),
        .lane_result_i(lane_result_i),
        .vrf_wr_en_o(vrf_wr_en_o), .vrf_wr_addr_o(vrf_wr_addr_o), .vrf_wr_grp_o(vrf_wr_grp_o),
        .vrf_wr_data_o(vrf_wr_data_o), .vrf_wr_be_o(vrf_wr_be_o), .vrf_wr_ready_i(vrf_wr_ready_i),
        .scalar_wr_en_o(scalar_wr_en_o), .scalar_wr_data_o(scalar_wr_data_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    // Lane array model: each valid lane computes on its 32-bit word.
    function automatic logic [31:0] lane_fn(input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] op, input logic [1:0] sew);
        logic [31:0] r;
        r = '0;
        case (op)
            OP_VADD: begin
                if (sew == 2'b00) for (int k = 0; k < 4; k++) r[8*k +: 8] = a[8*k +: 8] + b[8*k +: 8];
                else if (sew == 2'b01) for (int k = 0; k < 2; k++) r[16*k +: 16] = a[16*k +: 16] + b[16*k +: 16];
                else r = a + b;
            end
            OP_VMVVX, OP_VMVXS: r = a;
            default: r = a ^ b;
        endcase
        return r;
    endfunction

    always_comb begin
        lane_result_i = '0;
        for (int l = 0; l < L; l++)
            if (lane_valid_o[l])
                lane_result_i[32*l +: 32] = lane_fn(lane_data_a_o[32*l +: 32], lane_data_b_o[32*l +: 32],
                                                    lane_microop_o, lane_vsew_o);
    end

    // VRF read model: data appears one cycle after the read strobe.
    logic rd_pend = 1'b0;
    int   rd_a = 0, rd_b = 0, rd_g = 0;
    always @(negedge clk) begin
        rd_pend = vrf_rd_en_o;
        rd_a = int'(vrf_rd_addr_a_o);
        rd_b = int'(vrf_rd_addr_b_o);
        rd_g = int'(vrf_rd_grp_o);
    end
    always @(posedge clk) begin
        if (rd_pend)
            for (int b = 0; b < NB; b++) begin
                vrf_rd_data_a_i[8*b +: 8] = vmem[rd_a][rd_g*NB + b];
                vrf_rd_data_b_i[8*b +: 8] = vmem[rd_b][rd_g*NB + b];
            end
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int sewb_of(input logic [1:0] sew);
        return (sew == 2'b00) ? 1 : (sew == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] elem(input int r, input int sewb, input int e);
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < sewb; k++) v[8*k +: 8] = vmem[r][e*sewb + k];
        return v;
    endfunction

    function automatic logic [31:0] word_of(input int r, input int g, input int l);
        logic [31:0] v;
        for (int j = 0; j < 4; j++) v[8*j +: 8] = vmem[r][g*NB + 4*l + j];
        return v;
    endfunction

    function automatic logic [31:0] rep(input logic [31:0] s, input int sewb);
        logic [31:0] v;
        for (int j = 0; j < 4; j++) v[8*j +: 8] = s[8*(j % sewb) +: 8];
        return v;
    endfunction

    // Reference result of element e, from the instruction semantics.
    function automatic logic [31:0] ref_elem(input int e);
        int sewb;
        logic [31:0] a, b, m, r;
        sewb = sewb_of(cur_sew);
        m = (sewb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*sewb)) - 32'd1);
        a = elem(cur_vs2, sewb, e);
        b = cur_use ? cur_sc : elem(cur_vs1, sewb, e);
        if (cur_op == OP_VADD) r = a + b;
        else if (cur_op == OP_VMVVX) r = cur_sc;
        else r = a ^ b;
        return r & m;
    endfunction

    task automatic exp_grp(input int g, output logic [NB-1:0] be, output logic [DW-1:0] d);
        int sewb, e;
        logic [31:0] res;
        sewb = sewb_of(cur_sew);
        be = '0;
        d = '0;
        for (int b = 0; b < NB; b++) begin
            e = (g*NB + b) / sewb;
            if (e < cur_vl) begin
                be[b] = 1'b1;
                res = ref_elem(e);
                d[8*b +: 8] = res[8*(b % sewb) +: 8];
            end
        end
    endtask

    function automatic logic any_out();
        return |{vrf_rd_en_o, vrf_rd_addr_a_o, vrf_rd_addr_b_o, vrf_rd_grp_o, lane_valid_o,
                 lane_data_a_o, lane_data_b_o, lane_imm_o, lane_microop_o, lane_vsew_o,
                 vrf_wr_en_o, vrf_wr_addr_o, vrf_wr_grp_o, vrf_wr_data_o, vrf_wr_be_o,
                 scalar_wr_en_o, scalar_wr_data_o, done_o};
    endfunction

    task automatic scramble();
        instr_valid_i = 1'($urandom_range(0, 1));
        instr_microop_i = 5'($urandom);
        instr_vsew_i = 2'($urandom);
        instr_vl_i = 9'($urandom);
        instr_vs1_i = 5'($urandom);
        instr_vs2_i = 5'($urandom);
        instr_vd_i = 5'($urandom);
        instr_use_scalar_i = 1'($urandom);
        instr_scalar_i = $urandom;
        instr_imm_i = $urandom;
    endtask

    task automatic issue(input logic [4:0] op, input logic [1:0] sew, input int vl,
                         input int vs1, input int vs2, input int vd, input logic use_sc,
                         input logic [31:0] sc, input logic [31:0] imm,
                         input int stall_n, input bit rnd_stall, input bit rst_wb);
        int cyc, stalls, rd_cnt, wr_cnt, sc_cnt, g, sewb, epg, ngrp, guard, stall_left;
        bit fin, ev, vmvxs;
        logic [L-1:0] elv;
        logic [DW-1:0] ea, eb, ed, m;
        logic [NB-1:0] ebe;
        cur_op = op; cur_sew = sew; cur_vl = vl; cur_vs1 = vs1; cur_vs2 = vs2; cur_vd = vd;
        cur_use = use_sc; cur_sc = sc; cur_imm = imm;
        vmvxs = (op == OP_VMVXS);
        sewb = sewb_of(sew);
        epg = NB / sewb;
        ngrp = vmvxs ? 1 : (vl + epg - 1) / epg;
        stall_left = stall_n;
        stalls = 0; rd_cnt = 0; wr_cnt = 0; sc_cnt = 0; g = 0; fin = 0;
        guard = 0;
        while (!instr_ready_o && guard < 50) begin @(negedge clk); guard++; end
        chk("instr_ready_idle", DW'(instr_ready_o), DW'(1));
        instr_valid_i = 1'b1; instr_microop_i = op; instr_vsew_i = sew; instr_vl_i = 9'(vl);
        instr_vs1_i = 5'(vs1); instr_vs2_i = 5'(vs2); instr_vd_i = 5'(vd);
        instr_use_scalar_i = use_sc; instr_scalar_i = sc; instr_imm_i = imm;
        @(negedge clk);
        scramble();
        cyc = 1;
        while (!fin && cyc < 400) begin
            if (vrf_rd_en_o) begin
                rd_cnt++;
                chk("rd_grp", DW'(vrf_rd_grp_o), DW'(g));
                chk("rd_addr_a", DW'(vrf_rd_addr_a_o), DW'(vs2));
                chk("rd_addr_b", DW'(vrf_rd_addr_b_o), DW'(vs1));
            end
            if (lane_valid_o != '0) begin
                ea = '0; eb = '0;
                for (int l = 0; l < L; l++) begin
                    ev = vmvxs ? (l == 0) : ((g*epg + l*(4/sewb)) < vl);
                    elv[l] = ev;
                    if (ev) begin
                        ea[32*l +: 32] = (op == OP_VMVVX) ? rep(sc, sewb) : word_of(vs2, g, l);
                        eb[32*l +: 32] = vmvxs ? 32'd0 : use_sc ? rep(sc, sewb) : word_of(vs1, g, l);
                    end
                end
                last_lv = lane_valid_o;
                chk("lane_valid", DW'(lane_valid_o), DW'(elv));
                chk("lane_data_a", lane_data_a_o, ea);
                chk("lane_data_b", lane_data_b_o, eb);
                chk("lane_ctrl", DW'({lane_microop_o, lane_vsew_o, lane_imm_o}), DW'({op, sew, imm}));
            end
            if (vrf_wr_en_o) begin
                exp_grp(g, ebe, ed);
                for (int b = 0; b < NB; b++) m[8*b +: 8] = {8{ebe[b]}};
                chk("wr_addr", DW'(vrf_wr_addr_o), DW'(vd));
                chk("wr_grp", DW'(vrf_wr_grp_o), DW'(g));
                chk("wr_be", DW'(vrf_wr_be_o), DW'(ebe));
                chk("wr_data", vrf_wr_data_o & m, ed);
                last_wr_data = vrf_wr_data_o;
                last_wr_be = vrf_wr_be_o;
            end
            if (scalar_wr_en_o) begin
                sc_cnt++;
                last_scalar = scalar_wr_data_o;
                chk("scalar_data", DW'(scalar_wr_data_o), DW'(word_of(vs2, 0, 0)));
            end
            if (done_o) begin
                fin = 1;
                last_done_cyc = cyc;
                chk("done_ready_low", DW'(instr_ready_o), DW'(0));
                chk("done_cycle", DW'(cyc), DW'((vl == 0 && !vmvxs) ? 1 : 3*ngrp + stalls + 1));
                chk("rd_count", DW'(rd_cnt), DW'((vl == 0 && !vmvxs) ? 0 : ngrp));
                chk("wr_count", DW'(wr_cnt), DW'(vmvxs ? 0 : ngrp));
                chk("scalar_count", DW'(sc_cnt), DW'(vmvxs ? 1 : 0));
            end
            if (rst_wb && vrf_wr_en_o) begin
                instr_valid_i = 1'b0;
                vrf_wr_ready_i = 1'b0;
                rst_n = 1'b0;
                @(negedge clk);
                chk("rst_wb_outputs", DW'(any_out()), DW'(0));
                chk("rst_wb_ready", DW'(instr_ready_o), DW'(1));
                rst_n = 1'b1;
                vrf_wr_ready_i = 1'b1;
                return;
            end
            if (vrf_wr_en_o) begin
                if (stall_left > 0) begin
                    vrf_wr_ready_i = 1'b0; stall_left--; stalls++;
                end else if (rnd_stall && $urandom_range(0, 2) == 0) begin
                    vrf_wr_ready_i = 1'b0; stalls++;
                end else begin
                    vrf_wr_ready_i = 1'b1; wr_cnt++; g++;
                end
            end else begin
                vrf_wr_ready_i = 1'($urandom_range(0, 1));
            end
            if (fin) instr_valid_i = 1'b0;
            else begin
                scramble();
                @(negedge clk);
                cyc++;
            end
        end
        if (!fin) chk("done_timeout", DW'(0), DW'(1));
        vrf_wr_ready_i = 1'b1;
    endtask

    task automatic set_word(input int r, input int g, input int l, input logic [31:0] v);
        for (int j = 0; j < 4; j++) vmem[r][g*NB + 4*l + j] = v[8*j +: 8];
    endtask

    initial begin
        logic [1:0] rs;
        logic [4:0] rop;
        int rvl;
        for (int r = 0; r < 32; r++)
            for (int b = 0; b < 512; b++) vmem[r][b] = 8'($urandom);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", DW'(any_out()), DW'(0));
        chk("reset_ready", DW'(instr_ready_o), DW'(1));
        rst_n = 1'b1;
        @(negedge clk);

        // vadd SEW32 vl=8: vs2 lane i = i, vs1 lane i = 10*i
        for (int l = 0; l < L; l++) begin
            set_word(2, 0, l, 32'(l));
            set_word(1, 0, l, 32'(10*l));
        end
        issue(OP_VADD, 2'b10, 8, 1, 2, 3, 1'b0, 32'h0, 32'h0, 0, 0, 0);
        for (int l = 0; l < L; l++) chk("t1_sum", DW'(last_wr_data[32*l +: 32]), DW'(11*l));
        chk("t1_be", DW'(last_wr_be), DW'(32'hFFFF_FFFF));
        chk("t1_done_cyc", DW'(last_done_cyc), DW'(4));

        // vadd SEW8 vl=35: two groups, short tail group
        issue(OP_VADD, 2'b00, 35, 4, 5, 6, 1'b0, 32'h0, 32'h1234, 0, 0, 0);
        chk("t2_tail_be", DW'(last_wr_be), DW'(32'h0000_0007));
        chk("t2_tail_lv", DW'(last_lv), DW'(8'b0000_0001));
        chk("t2_done_cyc", DW'(last_done_cyc), DW'(7));

        // write stall of 5 cycles
        issue(OP_VADD, 2'b10, 8, 7, 8, 9, 1'b0, 32'h0, 32'h0, 5, 0, 0);
        chk("t3_done_cyc", DW'(last_done_cyc), DW'(9));

        // vmv.x.s
        set_word(10, 0, 0, 32'hDEAD_BEEF);
        issue(OP_VMVXS, 2'b10, 8, 11, 10, 12, 1'b0, 32'h0, 32'h0, 0, 0, 0);
        chk("t4_scalar", DW'(last_scalar), DW'(32'hDEAD_BEEF));
        chk("t4_done_cyc", DW'(last_done_cyc), DW'(4));

        // vl=0 then back-to-back
        issue(OP_VADD, 2'b10, 0, 1, 2, 3, 1'b0, 32'h0, 32'h0, 0, 0, 0);
        chk("t5_done_cyc", DW'(last_done_cyc), DW'(1));
        issue(OP_VADD, 2'b01, 16, 13, 14, 15, 1'b1, 32'hA5A5_1357, 32'h0, 0, 0, 0);
        chk("t5_b2b_done", DW'(last_done_cyc), DW'(4));

        // reset during WB, then normal instruction
        issue(OP_VADD, 2'b10, 8, 1, 2, 3, 1'b0, 32'h0, 32'h0, 0, 0, 1);
        issue(OP_VADD, 2'b10, 8, 1, 2, 3, 1'b0, 32'h0, 32'h0, 0, 0, 0);
        chk("t6_done_cyc", DW'(last_done_cyc), DW'(4));
        for (int l = 0; l < L; l++) chk("t6_sum", DW'(last_wr_data[32*l +: 32]), DW'(11*l));

        // randomized instructions with random write stalls
        for (int n = 0; n < 30; n++) begin
            rs = 2'($urandom);
            case ($urandom_range(0, 3))
                0: rop = OP_VADD;
                1: rop = OP_VMVVX;
                2: rop = OP_VMVXS;
                default: rop = OP_XOR;
            endcase
            if ($urandom_range(0, 7) == 0) rvl = 0;
            else rvl = (sewb_of(rs) == 4) ? $urandom_range(1, 128) : $urandom_range(1, 256);
            issue(rop, rs, rvl, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                  1'($urandom), $urandom, $urandom, 0, 1, 0);
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
